// File: rtl/sargantana_icache_pkg.sv
// Shared icache types and constants; holds the L2 request arbiter FSM encoding
// and the request-size helpers.
package sargantana_icache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } l2_arb_state_t;

  localparam logic [2:0] L2_SIZE_NC = 3'd3;

  // Requester slots on the two-way arbiter
  localparam int ARB_NC = 0;
  localparam int ARB_IC = 1;

  // log2 of the line size in bytes, as carried on the L2 size field
  function automatic logic [2:0] l2_line_size(input int line_w);
    return 3'($clog2(line_w / 8));
  endfunction

endpackage

// File: rtl/icache_rr_arb2.sv
// Two-requester round-robin arbiter. prio_q = 0 favours req[0], 1 favours req[1];
// on an enabled grant the priority moves to the losing slot.
module icache_rr_arb2 (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic [1:0] req,
  input  logic       upd_en,
  output logic [1:0] gnt,
  output logic       prio
);

  logic prio_q;

  always_comb begin
    gnt = 2'b00;
    if (!prio_q) begin
      if (req[0])      gnt = 2'b01;
      else if (req[1]) gnt = 2'b10;
    end else begin
      if (req[1])      gnt = 2'b10;
      else if (req[0]) gnt = 2'b01;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i)
      prio_q <= 1'b0;
    else if (upd_en && |req)
      prio_q <= gnt[0];
  end

  assign prio = prio_q;

endmodule

// File: rtl/icache_l2_req_arbiter.sv
// Merges icache line fills and NC bypass fetches onto one L2 channel, one
// transaction at a time. kill_i only suppresses line-fill responses.
module icache_l2_req_arbiter
  import sargantana_icache_pkg::*;
#(
  parameter int PADDR_W = 40,
  parameter int LINE_W  = 256
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               nc_req_valid_i,
  input  logic [PADDR_W-1:0] nc_req_paddr_i,
  output logic               nc_grant_valid_o,
  output logic [63:0]        nc_resp_data_o,
  input  logic               ic_req_valid_i,
  input  logic [PADDR_W-1:0] ic_req_paddr_i,
  output logic               ic_req_ready_o,
  output logic               ic_resp_valid_o,
  output logic [LINE_W-1:0]  ic_resp_data_o,
  input  logic               kill_i,
  output logic               l2_req_valid_o,
  input  logic               l2_req_ready_i,
  output logic [PADDR_W-1:0] l2_req_paddr_o,
  output logic               l2_req_nc_o,
  output logic [2:0]         l2_req_size_o,
  input  logic               l2_resp_valid_i,
  input  logic [LINE_W-1:0]  l2_resp_data_i,
  output logic               busy_o
);

  localparam logic [2:0] LINE_SIZE = l2_line_size(LINE_W);
  localparam int NWORDS = LINE_W / 64;
  localparam int WIDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  l2_arb_state_t state_q, state_d;

  logic               nc_pend_q;
  logic [PADDR_W-1:0] nc_paddr_q;
  logic [PADDR_W-1:0] req_paddr_q;
  logic               req_nc_q;
  logic [2:0]         req_size_q;
  logic               kill_q;
  logic               nc_grant_q;
  logic [63:0]        nc_data_q;
  logic               ic_resp_valid_q;
  logic [LINE_W-1:0]  ic_data_q;

  logic [1:0] arb_req, arb_gnt;
  logic       arb_prio;
  logic       in_idle, resp_fire, ic_fire;
  logic [63:0] nc_word;

  assign in_idle          = (state_q == IDLE);
  assign arb_req[ARB_NC]  = nc_pend_q;
  assign arb_req[ARB_IC]  = ic_req_valid_i;

  icache_rr_arb2 u_arb (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .req    (arb_req),
    .upd_en (in_idle),
    .gnt    (arb_gnt),
    .prio   (arb_prio)
  );

  always_comb begin
    state_d        = state_q;
    ic_req_ready_o = 1'b0;
    l2_req_valid_o = 1'b0;
    resp_fire      = 1'b0;
    case (state_q)
      IDLE: begin
        ic_req_ready_o = arb_gnt[ARB_IC];
        if (|arb_gnt) state_d = SEND;
      end
      SEND: begin
        l2_req_valid_o = 1'b1;
        if (l2_req_ready_i) state_d = WAIT;
      end
      WAIT: begin
        if (l2_resp_valid_i) begin
          resp_fire = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pick the addressed 64-bit word out of the returned line for NC fetches
  if (NWORDS == 1) begin : g_word_one
    assign nc_word = l2_resp_data_i[63:0];
  end else begin : g_word_sel
    logic [WIDX_W-1:0] widx;
    assign widx    = req_paddr_q[WIDX_W+2:3];
    assign nc_word = l2_resp_data_i[64*widx +: 64];
  end

  // A kill (same-cycle or remembered) drops the line fill, never an NC grant
  assign ic_fire = resp_fire && !req_nc_q && !kill_q && !kill_i;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q         <= IDLE;
      nc_pend_q       <= 1'b0;
      nc_paddr_q      <= '0;
      req_paddr_q     <= '0;
      req_nc_q        <= 1'b0;
      req_size_q      <= 3'd0;
      kill_q          <= 1'b0;
      nc_grant_q      <= 1'b0;
      nc_data_q       <= '0;
      ic_resp_valid_q <= 1'b0;
      ic_data_q       <= '0;
    end else begin
      state_q <= state_d;

      if (nc_req_valid_i) begin
        nc_pend_q  <= 1'b1;
        nc_paddr_q <= nc_req_paddr_i;
      end else if (in_idle && arb_gnt[ARB_NC]) begin
        nc_pend_q <= 1'b0;
      end

      if (in_idle && |arb_gnt) begin
        req_paddr_q <= arb_gnt[ARB_NC] ? nc_paddr_q : ic_req_paddr_i;
        req_nc_q    <= arb_gnt[ARB_NC];
        req_size_q  <= arb_gnt[ARB_NC] ? L2_SIZE_NC : LINE_SIZE;
      end

      if (state_d == IDLE)
        kill_q <= 1'b0;
      else if (kill_i && !in_idle && !req_nc_q)
        kill_q <= 1'b1;

      nc_grant_q <= resp_fire && req_nc_q;
      if (resp_fire && req_nc_q) nc_data_q <= nc_word;

      ic_resp_valid_q <= ic_fire;
      if (ic_fire) ic_data_q <= l2_resp_data_i;
    end
  end

  assign nc_grant_valid_o = nc_grant_q;
  assign nc_resp_data_o   = nc_data_q;
  assign ic_resp_valid_o  = ic_resp_valid_q;
  assign ic_resp_data_o   = ic_data_q;
  assign l2_req_paddr_o   = req_paddr_q;
  assign l2_req_nc_o      = req_nc_q;
  assign l2_req_size_o    = req_size_q;
  assign busy_o           = !in_idle || nc_pend_q;

  // The NC buffer must not issue a second request while one is still pending
  nc_double_req: assert property (@(posedge clk_i) disable iff (!rstn_i)
    !(nc_req_valid_i && nc_pend_q));

endmodule

// File: tb/tb_icache_l2_req_arbiter.sv
// Directed bench for icache_l2_req_arbiter: NC/IC paths, round-robin, kill and reset.
module tb_icache_l2_req_arbiter;

  localparam int PADDR_W = 40;
  localparam int LINE_W  = 256;

  logic               clk_i = 1'b0;
  logic               rstn_i;
  logic               nc_req_valid_i;
  logic [PADDR_W-1:0] nc_req_paddr_i;
  logic               nc_grant_valid_o;
  logic [63:0]        nc_resp_data_o;
  logic               ic_req_valid_i;
  logic [PADDR_W-1:0] ic_req_paddr_i;
  logic               ic_req_ready_o;
  logic               ic_resp_valid_o;
  logic [LINE_W-1:0]  ic_resp_data_o;
  logic               kill_i;
  logic               l2_req_valid_o;
  logic               l2_req_ready_i;
  logic [PADDR_W-1:0] l2_req_paddr_o;
  logic               l2_req_nc_o;
  logic [2:0]         l2_req_size_o;
  logic               l2_resp_valid_i;
  logic [LINE_W-1:0]  l2_resp_data_i;
  logic               busy_o;

  int n_chk  = 0;
  int n_fail = 0;

  icache_l2_req_arbiter #(.PADDR_W(PADDR_W), .LINE_W(LINE_W)) dut (
    .clk_i            (clk_i),
    .rstn_i           (rstn_i),
    .nc_req_valid_i   (nc_req_valid_i),
    .nc_req_paddr_i   (nc_req_paddr_i),
    .nc_grant_valid_o (nc_grant_valid_o),
    .nc_resp_data_o   (nc_resp_data_o),
    .ic_req_valid_i   (ic_req_valid_i),
    .ic_req_paddr_i   (ic_req_paddr_i),
    .ic_req_ready_o   (ic_req_ready_o),
    .ic_resp_valid_o  (ic_resp_valid_o),
    .ic_resp_data_o   (ic_resp_data_o),
    .kill_i           (kill_i),
    .l2_req_valid_o   (l2_req_valid_o),
    .l2_req_ready_i   (l2_req_ready_i),
    .l2_req_paddr_o   (l2_req_paddr_o),
    .l2_req_nc_o      (l2_req_nc_o),
    .l2_req_size_o    (l2_req_size_o),
    .l2_resp_valid_i  (l2_resp_valid_i),
    .l2_resp_data_i   (l2_resp_data_i),
    .busy_o           (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] mk_line(input logic [63:0] w3, w2, w1, w0);
    return {w3, w2, w1, w0};
  endfunction

  logic [LINE_W-1:0] line_a, line_b, line_c, line_d, line_e, line_f, line_g, line_h, line_i, line_j;

  initial begin
    line_a = mk_line(64'hDEADBEEF_CAFEF00D, 64'hA2, 64'hA1, 64'hA0);
    line_b = mk_line(64'hB3, 64'hB2, 64'hB1, 64'hB0);
    line_c = mk_line(64'hC3, 64'hC2, 64'h1111_2222_3333_4444, 64'hC0);
    line_d = mk_line(64'hD3, 64'hD2, 64'hD1, 64'hD0);
    line_e = mk_line(64'hE3, 64'h5555_6666_7777_8888, 64'hE1, 64'hE0);
    line_f = mk_line(64'hF3, 64'hF2, 64'hF1, 64'hF0);
    line_g = mk_line(64'h93, 64'h92, 64'h91, 64'h90);
    line_h = mk_line(64'h83, 64'h82, 64'h81, 64'h80);
    line_i = mk_line(64'h73, 64'h72, 64'h71, 64'h0123_4567_89AB_CDEF);
    line_j = mk_line(64'h63, 64'h62, 64'h61, 64'h60);

    rstn_i = 1'b0; nc_req_valid_i = 1'b0; nc_req_paddr_i = '0;
    ic_req_valid_i = 1'b0; ic_req_paddr_i = '0; kill_i = 1'b0;
    l2_req_ready_i = 1'b0; l2_resp_valid_i = 1'b0; l2_resp_data_i = '0;
    tick(); tick();

    // Reset values
    chk("rst_l2_valid", l2_req_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_nc_grant", nc_grant_valid_o, 0);
    chk("rst_ic_resp_valid", ic_resp_valid_o, 0);
    chk("rst_ic_ready", ic_req_ready_o, 0);
    chk("rst_nc_data", nc_resp_data_o, 0);
    chk("rst_ic_data", ic_resp_data_o, 0);
    chk("rst_size", l2_req_size_o, 0);
    chk("rst_paddr", l2_req_paddr_o, 0);
    rstn_i = 1'b1;
    tick();

    // NC fetch of word 3
    nc_req_valid_i = 1'b1; nc_req_paddr_i = 40'h80_0000_0018;
    tick();
    nc_req_valid_i = 1'b0;
    chk("nc_t1_busy", busy_o, 1);
    chk("nc_t1_no_req", l2_req_valid_o, 0);
    tick();
    chk("nc_t2_valid", l2_req_valid_o, 1);
    chk("nc_t2_nc", l2_req_nc_o, 1);
    chk("nc_t2_size", l2_req_size_o, 3);
    chk("nc_t2_paddr", l2_req_paddr_o, 40'h80_0000_0018);
    l2_req_ready_i = 1'b1;
    tick();
    l2_req_ready_i = 1'b0;
    chk("nc_wait_no_req", l2_req_valid_o, 0);
    l2_resp_valid_i = 1'b1; l2_resp_data_i = line_a;
    tick();
    l2_resp_valid_i = 1'b0;
    chk("nc_grant", nc_grant_valid_o, 1);
    chk("nc_data", nc_resp_data_o, 64'hDEADBEEF_CAFEF00D);
    chk("nc_done_busy", busy_o, 0);
    chk("nc_no_ic_resp", ic_resp_valid_o, 0);
    tick();
    chk("nc_grant_pulse", nc_grant_valid_o, 0);
    chk("nc_data_held", nc_resp_data_o, 64'hDEADBEEF_CAFEF00D);

    // IC fill with L2 back-pressure for 3 cycles
    ic_req_valid_i = 1'b1; ic_req_paddr_i = 40'h40_0000_0000;
    #1;
    chk("ic_ready", ic_req_ready_o, 1);
    tick();
    ic_req_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("ic_hold_valid", l2_req_valid_o, 1);
      chk("ic_hold_paddr", l2_req_paddr_o, 40'h40_0000_0000);
      chk("ic_hold_nc", l2_req_nc_o, 0);
      chk("ic_hold_size", l2_req_size_o, 5);
      tick();
    end
    chk("ic_still_valid", l2_req_valid_o, 1);
    l2_req_ready_i = 1'b1;
    tick();
    l2_req_ready_i = 1'b0;
    l2_resp_valid_i = 1'b1; l2_resp_data_i = line_b;
    tick();
    l2_resp_valid_i = 1'b0;
    chk("ic_resp_valid", ic_resp_valid_o, 1);
    chk("ic_resp_data", ic_resp_data_o, line_b);
    chk("ic_no_nc_grant", nc_grant_valid_o, 0);
    tick();
    chk("ic_resp_pulse", ic_resp_valid_o, 0);
    chk("ic_data_held", ic_resp_data_o, line_b);

    // Round-robin: NC first, then IC, then NC again
    rstn_i = 1'b0; tick(); rstn_i = 1'b1; tick();
    nc_req_valid_i = 1'b1; nc_req_paddr_i = 40'h80_0000_0008;
    tick();
    nc_req_valid_i = 1'b0;
    ic_req_valid_i = 1'b1; ic_req_paddr_i = 40'h40_0000_0040;
    #1;
    chk("rr1_ic_loses", ic_req_ready_o, 0);
    tick();
    chk("rr1_nc_first", l2_req_nc_o, 1);
    chk("rr1_nc_paddr", l2_req_paddr_o, 40'h80_0000_0008);
    nc_req_valid_i = 1'b1; nc_req_paddr_i = 40'h80_0000_0010;
    l2_req_ready_i = 1'b1;
    tick();
    nc_req_valid_i = 1'b0; l2_req_ready_i = 1'b0;
    chk("rr1_busy_no_ready", ic_req_ready_o, 0);
    l2_resp_valid_i = 1'b1; l2_resp_data_i = line_c;
    tick();
    l2_resp_valid_i = 1'b0;
    chk("rr1_nc_grant", nc_grant_valid_o, 1);
    chk("rr1_nc_data", nc_resp_data_o, 64'h1111_2222_3333_4444);
    chk("rr2_ic_wins", ic_req_ready_o, 1);
    tick();
    ic_req_valid_i = 1'b0;
    chk("rr2_ic_nc", l2_req_nc_o, 0);
    chk("rr2_ic_paddr", l2_req_paddr_o, 40'h40_0000_0040);
    l2_req_ready_i = 1'b1;
    tick();
    l2_req_ready_i = 1'b0;
    l2_resp_valid_i = 1'b1; l2_resp_data_i = line_d;
    tick();
    l2_resp_valid_i = 1'b0;
    chk("rr2_ic_resp", ic_resp_valid_o, 1);
    chk("rr2_ic_data", ic_resp_data_o, line_d);
    chk("rr2_nc_pending", busy_o, 1);
    tick();
    chk("rr3_nc_next", l2_req_nc_o, 1);
    chk("rr3_nc_paddr", l2_req_paddr_o, 40'h80_0000_0010);
    l2_req_ready_i = 1'b1;
    tick();
    l2_req_ready_i = 1'b0;
    l2_resp_valid_i = 1'b1; l2_resp_data_i = line_e;
    tick();
    l2_resp_valid_i = 1'b0;
    chk("rr3_nc_grant", nc_grant_valid_o, 1);
    chk("rr3_nc_data", nc_resp_data_o, 64'h5555_6666_7777_8888);
    chk("rr3_idle", busy_o, 0);

    // Kill in WAIT before the response
    ic_req_valid_i = 1'b1; ic_req_paddr_i = 40'h40_0000_0080;
    tick();
    ic_req_valid_i = 1'b0; l2_req_ready_i = 1'b1;
    tick();
    l2_req_ready_i = 1'b0; kill_i = 1'b1;
    tick();
    kill_i = 1'b0;
    l2_resp_valid_i = 1'b1; l2_resp_data_i = line_f;
    tick();
    l2_resp_valid_i = 1'b0;
    chk("kill_wait_no_resp", ic_resp_valid_o, 0);
    chk("kill_wait_data_kept", ic_resp_data_o, line_d);
    chk("kill_wait_consumed", busy_o, 0);
    // Next request accepted; kill coincident with the response
    ic_req_valid_i = 1'b1; ic_req_paddr_i = 40'h40_0000_00C0;
    #1;
    chk("kill_next_ready", ic_req_ready_o, 1);
    tick();
    ic_req_valid_i = 1'b0; l2_req_ready_i = 1'b1;
    tick();
    l2_req_ready_i = 1'b0;
    l2_resp_valid_i = 1'b1; l2_resp_data_i = line_g; kill_i = 1'b1;
    tick();
    l2_resp_valid_i = 1'b0; kill_i = 1'b0;
    chk("kill_same_no_resp", ic_resp_valid_o, 0);
    chk("kill_same_data_kept", ic_resp_data_o, line_d);
    // A clean fill afterwards is delivered
    ic_req_valid_i = 1'b1; ic_req_paddr_i = 40'h40_0000_0100;
    tick();
    ic_req_valid_i = 1'b0; l2_req_ready_i = 1'b1;
    tick();
    l2_req_ready_i = 1'b0;
    l2_resp_valid_i = 1'b1; l2_resp_data_i = line_h;
    tick();
    l2_resp_valid_i = 1'b0;
    chk("post_kill_resp", ic_resp_valid_o, 1);
    chk("post_kill_data", ic_resp_data_o, line_h);

    // NC transaction survives kill in SEND and WAIT
    nc_req_valid_i = 1'b1; nc_req_paddr_i = 40'h80_0000_0000;
    tick();
    nc_req_valid_i = 1'b0;
    tick();
    kill_i = 1'b1;
    chk("nckill_send_nc", l2_req_nc_o, 1);
    l2_req_ready_i = 1'b1;
    tick();
    l2_req_ready_i = 1'b0;
    tick();
    l2_resp_valid_i = 1'b1; l2_resp_data_i = line_i;
    tick();
    l2_resp_valid_i = 1'b0; kill_i = 1'b0;
    chk("nckill_grant", nc_grant_valid_o, 1);
    chk("nckill_data", nc_resp_data_o, 64'h0123_4567_89AB_CDEF);
    chk("nckill_no_ic", ic_resp_valid_o, 0);
    chk("nckill_ic_data", ic_resp_data_o, line_h);

    // Reset during WAIT, then a stray response
    ic_req_valid_i = 1'b1; ic_req_paddr_i = 40'h40_0000_0140;
    tick();
    ic_req_valid_i = 1'b0; l2_req_ready_i = 1'b1;
    tick();
    l2_req_ready_i = 1'b0;
    rstn_i = 1'b0;
    tick();
    rstn_i = 1'b1;
    l2_resp_valid_i = 1'b1; l2_resp_data_i = line_j;
    tick();
    l2_resp_valid_i = 1'b0;
    chk("stray_no_ic_resp", ic_resp_valid_o, 0);
    chk("stray_no_nc_grant", nc_grant_valid_o, 0);
    chk("stray_busy", busy_o, 0);
    chk("stray_no_req", l2_req_valid_o, 0);
    chk("stray_ic_data", ic_resp_data_o, 0);
    tick();
    chk("stray_late_ic_resp", ic_resp_valid_o, 0);
    chk("stray_late_busy", busy_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_l2_req_arbiter.md
# icache_l2_req_arbiter

- Merges the two instruction-side L2 request sources onto one L2 request/response channel:
  - cacheable line fills from the L1 instruction cache;
  - 8-byte non-cacheable fetches from the NC icache bypass buffer.
- Sits directly downstream of the NC bypass buffer. It consumes the buffer's single-cycle NC request pulse and address, and returns the grant pulse plus the 64-bit NC word the buffer latches.
- One transaction outstanding at a time.
- Round-robin choice between the two sources.
- A kill suppresses stale line fills. It never cancels NC traffic.

## Interface
- PADDR_W, 40, physical address width
- LINE_W, 256, L2 response / icache line width (multiple of 64, ≥ 64)
- clk_i  in  1  clock
- rstn_i  in  1  reset, synchronous, active-low
- nc_req_valid_i  in  1  single-cycle NC request pulse
- nc_req_paddr_i  in  PADDR_W  NC address, 8-byte aligned
- nc_grant_valid_o  out  1  NC response pulse (drives the NC buffer's L2 grant input)
- nc_resp_data_o  out  64  NC word, held until the next NC response
- ic_req_valid_i  in  1  icache line-fill request, level, held until accepted
- ic_req_paddr_i  in  PADDR_W  line address
- ic_req_ready_o  out  1  icache request accepted this cycle
- ic_resp_valid_o  out  1  line-fill response pulse
- ic_resp_data_o  out  LINE_W  line data, held until the next fill
- kill_i  in  1  fetch flush / icache invalidate
- l2_req_valid_o  out  1  L2 request valid
- l2_req_ready_i  in  1  L2 request ready
- l2_req_paddr_o  out  PADDR_W  L2 request address
- l2_req_nc_o  out  1  1 = non-cacheable request
- l2_req_size_o  out  3  log2 of bytes: 3 for NC, log2(LINE_W/8) for a line
- l2_resp_valid_i  in  1  L2 response valid
- l2_resp_data_i  in  LINE_W  L2 response data
- busy_o  out  1  state ≠ IDLE or an NC request is pending

## Operation
- **NC capture:** nc_req_valid_i sets nc_pend_q and latches the address.
  - A second pulse while nc_pend_q = 1 is a protocol violation (flagged by an assertion). The address is overwritten.
- **IDLE:** candidates are nc_pend_q and ic_req_valid_i.
  - prio_q = 0 favours NC; prio_q = 1 favours IC.
  - The winner's address and type are registered and the state moves to SEND. prio_q becomes the loser's value.
  - If IC wins, ic_req_ready_o = 1 combinationally in that cycle. If NC wins, nc_pend_q clears.
- **SEND:** l2_req_valid_o = 1; address, nc and size fields are stable.
  - Move to WAIT on l2_req_ready_i.
  - A request is never withdrawn once valid.
- **WAIT:** on l2_resp_valid_i, move to IDLE. Next cycle:
  - NC transaction: nc_grant_valid_o pulses; nc_resp_data_o = l2_resp_data_i[64·paddr[k:3] +: 64], with k = log2(LINE_W/8) − 1.
  - IC transaction: ic_resp_valid_o pulses and ic_resp_data_o is loaded, unless killed.
- **kill_i:**
  - In SEND or WAIT during an IC transaction: sets kill_q. The response is still consumed, but ic_resp_valid_o stays 0, and ic_resp_data_o keeps its old value.
  - kill_i in the same cycle as l2_resp_valid_i also suppresses.
  - kill_q clears on entry to IDLE.
  - kill_i never affects nc_pend_q or an NC transaction. The NC buffer relies on receiving its grant even after a kill.
- l2_resp_valid_i outside WAIT is ignored.

## Timing
- **Reset values:** all outputs 0, state IDLE, nc_pend_q = 0, prio_q = 0, kill_q = 0, data registers 0.
- **NC path:** pulse at cycle t → l2_req_valid_o at t+2 at the earliest (pending at t+1, arbitration at t+1, SEND at t+2).
- **IC path:** valid at t in IDLE and winning → ready at t, l2_req_valid_o at t+1.
- **Responses:** l2_resp_valid_i at t → response pulse at t+1, state IDLE at t+1. The next arbitration can happen at t+1, so the next l2_req_valid_o is at t+2 at the earliest.
- An NC pulse arriving at cycle t is visible as pending from t+1, even if the state is busy.
- Reset mid-transaction returns to IDLE and drops everything.
  - A late L2 response after reset is ignored.
  - Reset of the NC buffer is assumed concurrent (same rstn_i).

## Structure
- Add to sargantana_icache_pkg:
  - l2_arb_state_t enum: IDLE, SEND, WAIT;
  - L2_SIZE_NC = 3'd3;
  - function l2_line_size(LINE_W).
- One sub-module, icache_rr_arb2: two-request round-robin with priority register and update enable. It is reused by future L2 clients.

## Test plan
- Reset, then NC pulse at address 0x80_0000_0018 with LINE_W = 256:
  - expect l2_req at t+2 with nc = 1, size = 3, paddr = 0x80_0000_0018;
  - L2 returns a line whose word 3 is 0xDEADBEEF_CAFEF00D;
  - expect nc_grant pulse and nc_resp_data_o = 0xDEADBEEF_CAFEF00D one cycle later.
- IC request for 0x40_0000_0000 with l2_req_ready_i low for 3 cycles:
  - the request is held stable 3 cycles;
  - ic_resp_valid_o pulses once with the line.
- NC pending and ic_req_valid_i high simultaneously after reset:
  - NC issued first, then IC;
  - repeat with both again → IC first (round-robin).
- IC fill in WAIT with kill_i asserted:
  - response consumed, ic_resp_valid_o stays 0, ic_resp_data_o unchanged, next request accepted.
- NC transaction with kill_i asserted in SEND and again in WAIT:
  - nc_grant_valid_o still pulses with correct data.
- rstn_i low during WAIT, then a stray l2_resp_valid_i:
  - no output pulses, busy_o = 0.
